// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : instruction fetch unit feeding decode through a prefetch queue
// Rev 1.0
// ============================================================================
module fetch_queue #(
   parameter int                  PC_WIDTH = 32,
   parameter int                  IWIDTH   = 32,
   parameter int                  QDEPTH   = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                      fq_clk,
   input  logic                      fq_rst,
   input  logic                      fq_i_ce,
   input  logic                      fq_i_redirect,
   input  logic [PC_WIDTH-1:0]       fq_i_target,
   output logic                      fq_o_imem_req,
   output logic [PC_WIDTH-1:0]       fq_o_imem_addr,
   input  logic [IWIDTH-1:0]         fq_i_imem_data,
   output logic                      fq_o_valid,
   input  logic                      fq_i_ready,
   output logic [IWIDTH-1:0]         fq_o_instr,
   output logic [PC_WIDTH-1:0]       fq_o_pc,
   output logic [$clog2(QDEPTH):0]   fq_o_count
);

   localparam int               PTR_W   = $clog2(QDEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(QDEPTH);

   if ((QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fetch_queue: QDEPTH must be a power of two and at least 2");
   end

   logic [PC_WIDTH-1:0] fetch_pc_q,    fetch_pc_d;
   logic                inflight_q,    inflight_d;
   logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0]    rd_ptr_q,      rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q,      wr_ptr_d;
   logic [CNT_W-1:0]    count_q,       count_d;
   logic                post_rst_q,    post_rst_d;

   logic [IWIDTH-1:0]   ent_instr_q [QDEPTH];
   logic [PC_WIDTH-1:0] ent_pc_q    [QDEPTH];

   logic                head_valid;
   logic                pop;
   logic                push;
   logic                req;
   logic [CNT_W:0]      credit_use;
   logic                unused_target_lsbs;

   assign unused_target_lsbs = ^fq_i_target[1:0];

   // Credit: entries held + response in flight - entry leaving this cycle
   always_comb begin
      head_valid = (count_q != '0);
      pop        = head_valid & fq_i_ready;
      push       = inflight_q & ~fq_i_redirect & ~fq_rst;
      credit_use = {1'b0, count_q}
                 + {{CNT_W{1'b0}}, inflight_q}
                 - {{CNT_W{1'b0}}, pop};
      req        = fq_i_ce & ~fq_i_redirect & ~fq_rst & ~post_rst_q
                 & (credit_use < DEPTH_C);
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      post_rst_d    = 1'b0;

      if (fq_i_redirect) begin
         // Flush wins over any same-cycle push or pop
         fetch_pc_d = {fq_i_target[PC_WIDTH-1:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (req) begin
            fetch_pc_d    = fetch_pc_q + PC_WIDTH'(4);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
         end
      end
   end

   always_ff @(posedge fq_clk) begin
      if (fq_rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         post_rst_q    <= 1'b1;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         post_rst_q    <= post_rst_d;
      end
   end

   always_ff @(posedge fq_clk) begin
      if (push) begin
         ent_instr_q[wr_ptr_q] <= fq_i_imem_data;
         ent_pc_q[wr_ptr_q]    <= inflight_pc_q;
      end
   end

   assign fq_o_imem_req  = req;
   assign fq_o_imem_addr = fetch_pc_q;
   assign fq_o_valid     = head_valid;
   assign fq_o_instr     = head_valid ? ent_instr_q[rd_ptr_q] : '0;
   assign fq_o_pc        = head_valid ? ent_pc_q[rd_ptr_q] : '0;
   assign fq_o_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue : directed scenarios plus random traffic against a queue-based model
module tb_fetch_queue;

   localparam int QD = 4;

   logic        clk = 1'b0;
   logic        rst, ce, redirect, ready;
   logic [31:0] target, imem_data;
   logic        o_req, o_valid;
   logic [31:0] o_addr, o_instr, o_pc;
   logic [2:0]  o_count;

   logic        w_ce;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc;
   logic [2:0]  w_count;

   always #5 clk = ~clk;

   fetch_queue #(.PC_WIDTH(32), .IWIDTH(32), .QDEPTH(QD), .RESET_PC(32'h0)) dut (
      .fq_clk(clk), .fq_rst(rst), .fq_i_ce(ce), .fq_i_redirect(redirect),
      .fq_i_target(target), .fq_o_imem_req(o_req), .fq_o_imem_addr(o_addr),
      .fq_i_imem_data(imem_data), .fq_o_valid(o_valid), .fq_i_ready(ready),
      .fq_o_instr(o_instr), .fq_o_pc(o_pc), .fq_o_count(o_count));

   fetch_queue #(.PC_WIDTH(32), .IWIDTH(32), .QDEPTH(QD), .RESET_PC(32'hFFFF_FFF8)) dut_w (
      .fq_clk(clk), .fq_rst(rst), .fq_i_ce(w_ce), .fq_i_redirect(1'b0),
      .fq_i_target(32'h0), .fq_o_imem_req(w_req), .fq_o_imem_addr(w_addr),
      .fq_i_imem_data(32'h0), .fq_o_valid(w_valid), .fq_i_ready(1'b1),
      .fq_o_instr(w_instr), .fq_o_pc(w_pc), .fq_o_count(w_count));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of (pc, instr) pairs plus fetch PC and one pending response
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_fpc = 32'h0;
   bit          m_pend = 1'b0;
   logic [31:0] m_pend_pc, m_pend_data;
   bit          m_post_rst = 1'b0;
   bit          scramble = 1'b0;
   bit          chk_en = 1'b0;
   bit          e_valid, e_req;
   logic [31:0] last_req_addr = 32'h0;
   logic        m_req_s = 1'b0;
   logic [31:0] m_data_s = 32'h0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return scramble ? (a ^ 32'h5A5A_A5A5) : a;
   endfunction

   always @(negedge clk) begin
      int sz;
      bit pop;
      sz      = mq.size();
      e_valid = (sz != 0);
      pop     = e_valid && ready;
      e_req   = !rst && !m_post_rst && ce && !redirect && ((sz + int'(m_pend) - int'(pop)) < QD);
      if (chk_en) begin
         chk("valid", {31'b0, o_valid}, {31'b0, e_valid});
         chk("count", {29'b0, o_count}, 32'(sz));
         chk("req", {31'b0, o_req}, {31'b0, e_req});
         if (e_req) chk("req_addr", o_addr, m_fpc);
         if (e_valid) begin
            chk("head_pc", o_pc, mq[0].pc);
            chk("head_instr", o_instr, mq[0].ins);
         end
      end
      m_req_s  = o_req;
      m_data_s = memf(o_addr);
      if (o_req) last_req_addr = o_addr;
   end

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_fpc      = 32'h0;
         m_pend     = 1'b0;
         m_post_rst = 1'b1;
      end else begin
         m_post_rst = 1'b0;
         if (redirect) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = target & ~32'h3;
         end else begin
            if (e_valid && ready) void'(mq.pop_front());
            if (m_pend) mq.push_back('{pc: m_pend_pc, ins: m_pend_data});
            if (mq.size() > QD) chk("overflow", 32'(mq.size()), 32'(QD));
            m_pend = e_req;
            if (e_req) begin
               m_pend_pc   = m_fpc;
               m_pend_data = memf(m_fpc);
               m_fpc       = m_fpc + 32'd4;
            end
         end
      end
   end

   // Instruction memory: one-cycle read latency, junk when no request
   always @(posedge clk) begin
      #1;
      imem_data = m_req_s ? m_data_s : $urandom();
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          rq, vc, w_n, gap_i;
      logic [31:0] w_addrs [4];
      logic [31:0] w_exp   [4];
      logic [31:0] gap_last;

      rst = 1'b1; ce = 1'b0; redirect = 1'b0; ready = 1'b0;
      target = 32'h0; imem_data = 32'h0; w_ce = 1'b0;
      step(); step();
      chk_en = 1'b1;
      rst = 1'b0; ce = 1'b1; ready = 1'b1; w_ce = 1'b1;

      // Reset values, first-request latency, wrap of the second instance
      rq = -1; vc = -1; w_n = 0;
      w_exp[0] = 32'hFFFF_FFF8; w_exp[1] = 32'hFFFF_FFFC;
      w_exp[2] = 32'h0000_0000; w_exp[3] = 32'h0000_0004;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("rst_valid", {31'b0, o_valid}, 32'h0);
            chk("rst_req", {31'b0, o_req}, 32'h0);
            chk("rst_count", {29'b0, o_count}, 32'h0);
            chk("rst_instr", o_instr, 32'h0);
            chk("rst_pc", o_pc, 32'h0);
         end
         if (o_req && rq < 0) rq = c;
         if (o_valid && vc < 0) begin
            vc = c;
            chk("first_head_pc", o_pc, 32'h0);
            chk("first_head_instr", o_instr, 32'h0);
         end
         if (vc >= 0 && c == vc + 1) chk("second_head_pc", o_pc, 32'h4);
         if (vc >= 0 && c == vc + 2) chk("third_head_pc", o_pc, 32'h8);
         if (w_req && w_n < 4) begin
            w_addrs[w_n] = w_addr;
            w_n++;
         end
      end
      chk("first_req_cycle", 32'(rq), 32'd1);
      chk("req_to_head", 32'(vc - rq), 32'd2);
      chk("wrap_req_count", 32'(w_n), 32'd4);
      for (int i = 0; i < 4; i++) chk("wrap_addr", w_addrs[i], w_exp[i]);
      step();

      // Back-pressure: queue saturates, requests stop
      ready = 1'b0;
      repeat (10) step();
      @(negedge clk);
      chk("full_count", {29'b0, o_count}, 32'd4);
      chk("full_req", {31'b0, o_req}, 32'h0);
      step();
      ready = 1'b1;
      repeat (8) step();

      // Redirect with three entries queued and one response in flight
      ready = 1'b0; redirect = 1'b1; target = 32'h200;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 20 && o_count != 3'd3; i++) step();
      chk("fill_three", {29'b0, o_count}, 32'd3);
      redirect = 1'b1; target = 32'h103;
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("redir_count", {29'b0, o_count}, 32'h0);
      chk("redir_req", {31'b0, o_req}, 32'h1);
      chk("redir_addr", o_addr, 32'h100);
      step();
      ready = 1'b1;
      for (int i = 0; i < 10 && !o_valid; i++) step();
      chk("redir_head_pc", o_pc, 32'h100);
      repeat (6) step();

      // Fetch enable gap
      gap_last = last_req_addr;
      ce = 1'b0;
      for (gap_i = 0; gap_i < 3; gap_i++) begin
         @(negedge clk);
         chk("gap_req", {31'b0, o_req}, 32'h0);
         step();
      end
      ce = 1'b1;
      @(negedge clk);
      chk("resume_req", {31'b0, o_req}, 32'h1);
      chk("resume_addr", o_addr, gap_last + 32'd4);
      step();
      repeat (4) step();

      // Reset while full
      ready = 1'b0;
      for (int i = 0; i < 20 && o_count != 3'd4; i++) step();
      chk("pre_rst_full", {29'b0, o_count}, 32'd4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {31'b0, o_valid}, 32'h0);
      chk("mid_rst_req", {31'b0, o_req}, 32'h0);
      chk("mid_rst_count", {29'b0, o_count}, 32'h0);
      chk("mid_rst_instr", o_instr, 32'h0);
      chk("mid_rst_pc", o_pc, 32'h0);
      step();
      @(negedge clk);
      chk("refetch_req", {31'b0, o_req}, 32'h1);
      chk("refetch_addr", o_addr, 32'h0);
      step();

      // Random traffic
      scramble = 1'b1;
      for (int i = 0; i < 800; i++) begin
         ce       = ($urandom % 10) < 8;
         ready    = ($urandom % 10) < 6;
         redirect = ($urandom % 20) == 0;
         target   = $urandom();
         rst      = ($urandom % 150) == 0;
         step();
      end
      rst = 1'b0; redirect = 1'b0; ce = 1'b0; ready = 1'b1;
      repeat (8) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
